// File: rtl/twi_pkg.sv
// Shared TWI bus-conditioner definitions: FSM encoding and default timing constants.
package twi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVE   = 3'd1,
    ST_REC_LOW  = 3'd2,
    ST_REC_STOP = 3'd3,
    ST_WAIT_REL = 3'd4
  } twi_state_e;

  localparam int unsigned DEF_FILTER_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2500000;
  localparam int unsigned DEF_REC_CYCLES     = 16;

  // Pads are released in every state that belongs to stuck-bus recovery.
  function automatic logic in_recovery(input twi_state_e s);
    return (s == ST_REC_LOW) || (s == ST_REC_STOP) || (s == ST_WAIT_REL);
  endfunction

endpackage

// File: rtl/twi_glitch_filter.sv
// One bus line: 2-flop synchroniser followed by a FILTER_CYCLES-deep disagreement filter.
module twi_glitch_filter
  import twi_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic pad_i,
  output logic filt_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // Any clock where the synchronised level agrees with the output restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/twi_bus_conditioner.sv
// TWI pad conditioner: filtered levels to the slave core, START/STOP detection,
// and stuck-SCL recovery that feeds the core a synthetic STOP.
module twi_bus_conditioner
  import twi_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned REC_CYCLES     = DEF_REC_CYCLES
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pad_scl_i,
  input  logic       pad_sda_i,
  output logic       pad_scl_o,
  output logic       pad_sda_o,
  output logic       core_scl_o,
  output logic       core_sda_o,
  input  logic       core_scl_i,
  input  logic       core_sda_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       timeout_o,
  input  logic       clr_timeout_i,
  output logic [2:0] dbg_state_o
);

  localparam int unsigned    TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned    REC_W    = $clog2(REC_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(REC_CYCLES - 1);

  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic start_raw, stop_raw, timeout_hit;

  twi_state_e        state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [REC_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic              timeout_q, timeout_d;
  logic              pad_scl_q, pad_sda_q;

  twi_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filt (
    .clk_i(clk_i), .rstn_i(rstn_i), .pad_i(pad_scl_i), .filt_o(scl_f)
  );

  twi_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filt (
    .clk_i(clk_i), .rstn_i(rstn_i), .pad_i(pad_sda_i), .filt_o(sda_f)
  );

  // SCL must be high both before and after the SDA edge, so simultaneous edges are ignored.
  assign start_raw   = scl_f & scl_prev_q &  sda_prev_q & ~sda_f;
  assign stop_raw    = scl_f & scl_prev_q & ~sda_prev_q &  sda_f;
  assign timeout_hit = (state_q == ST_ACTIVE) && (to_cnt_q == TO_MAX);

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = '0;
    to_cnt_d  = '0;
    timeout_d = timeout_hit | (timeout_q & ~clr_timeout_i);
    unique case (state_q)
      ST_IDLE: begin
        if (start_raw) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!scl_f) to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        if (timeout_hit)   state_d = ST_REC_LOW;
        else if (stop_raw) state_d = ST_IDLE;
      end
      ST_REC_LOW: begin
        if (rec_cnt_q == REC_LAST) state_d = ST_REC_STOP;
        else                       rec_cnt_d = rec_cnt_q + 1'b1;
      end
      ST_REC_STOP: begin
        if (rec_cnt_q == REC_LAST) state_d = ST_WAIT_REL;
        else                       rec_cnt_d = rec_cnt_q + 1'b1;
      end
      ST_WAIT_REL: begin
        if (scl_f && sda_f) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      rec_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      pad_scl_q  <= 1'b1;
      pad_sda_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
      timeout_q  <= timeout_d;
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      // Keyed on the next state so the pads are released from the first recovery cycle.
      pad_scl_q  <= in_recovery(state_d) ? 1'b1 : core_scl_i;
      pad_sda_q  <= in_recovery(state_d) ? 1'b1 : core_sda_i;
    end
  end

  always_comb begin
    core_scl_o = scl_f;
    core_sda_o = sda_f;
    if (state_q == ST_REC_LOW) begin
      core_scl_o = 1'b1;
      core_sda_o = 1'b0;
    end else if (state_q == ST_REC_STOP) begin
      core_scl_o = 1'b1;
      core_sda_o = 1'b1;
    end
  end

  assign start_o     = start_raw & ~in_recovery(state_q);
  assign stop_o      = stop_raw & ~in_recovery(state_q);
  assign busy_o      = (state_q == ST_ACTIVE);
  assign timeout_o   = timeout_q;
  assign pad_scl_o   = pad_scl_q;
  assign pad_sda_o   = pad_sda_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/twi_bus_conditioner.md
TWI_BUS_CONDITIONER -- requirements
Module: twi_bus_conditioner

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4, meaning consecutive clocks a line must disagree before the filtered value changes (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2500000, meaning clocks of continuous filtered SCL low before bus recovery (25 ms at 100 MHz).
REQ-003 SHALL have parameter REC_CYCLES, default 16, meaning the length in clocks of each synthetic STOP phase.
REQ-004 SHALL have port clk_i  in  1  system clock.
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports pad_scl_i, pad_sda_i  in  1  raw bus levels from pads.
REQ-007 SHALL have ports pad_scl_o, pad_sda_o  out  1  open-drain drive to pads (0 = pull low, 1 = release).
REQ-008 SHALL have ports core_scl_o, core_sda_o  out  1  conditioned levels to the TWI slave core.
REQ-009 SHALL have ports core_scl_i, core_sda_i  in  1  open-drain requests from the TWI slave core.
REQ-010 SHALL have ports start_o, stop_o  out  1  single-cycle START / STOP detection pulses.
REQ-011 SHALL have port busy_o  out  1  transaction in progress.
REQ-012 SHALL have port timeout_o  out  1  sticky stuck-bus flag.
REQ-013 SHALL have port clr_timeout_i  in  1  single-cycle clear of timeout_o.

Function
REQ-014 SHALL synchronise each pad input through 2 flops, then filter: filtered value changes only after FILTER_CYCLES consecutive clocks of disagreement; any agreement clears the per-line counter.
REQ-015 SHALL give pad-to-core_*_o latency of exactly 2 + FILTER_CYCLES clocks, so a pulse of FILTER_CYCLES-1 clocks never reaches the core.
REQ-016 SHALL pulse start_o for 1 clock when filtered SDA falls while filtered SCL is high and unchanged in that cycle; stop_o likewise on SDA rise.
REQ-017 SHALL report no START/STOP when filtered SCL and SDA change in the same cycle.
REQ-018 SHALL register pad_*_o from core_*_i with 1-clock latency, except forced to 1 in recovery states.
REQ-019 SHALL implement FSM IDLE, ACTIVE, REC_LOW, REC_STOP, WAIT_REL.
REQ-020 IDLE->ACTIVE on START; ACTIVE->IDLE on STOP; a START in ACTIVE (repeated START) stays in ACTIVE.
REQ-021 SHALL count clocks with filtered SCL low in ACTIVE, clearing the counter on SCL high; on reaching TIMEOUT_CYCLES SHALL enter REC_LOW and set timeout_o.
REQ-022 In REC_LOW, core_scl_o=1 and core_sda_o=0 for REC_CYCLES clocks, then REC_STOP.
REQ-023 In REC_STOP, core_scl_o=1 and core_sda_o=1 for REC_CYCLES clocks (synthetic STOP to the core), then WAIT_REL.
REQ-024 WAIT_REL SHALL pass filtered levels to the core and go to IDLE once filtered SCL and SDA are both 1.
REQ-025 start_o/stop_o SHALL be suppressed in REC_LOW, REC_STOP and WAIT_REL.
REQ-026 busy_o SHALL be 1 exactly in ACTIVE.
REQ-027 timeout_o SHALL be cleared by clr_timeout_i; set wins over a simultaneous clear.
REQ-028 Timeout counter SHALL saturate, never wrap, and be sized by ceil(log2(TIMEOUT_CYCLES+1)).

Reset
REQ-029 On rstn_i low, SHALL set sync/filter flops to 1, FSM to IDLE, counters to 0.
REQ-030 Reset outputs: pad_*_o=1, core_*_o=1, start_o=0, stop_o=0, busy_o=0, timeout_o=0.
REQ-031 Reset asserted mid-recovery SHALL abort to IDLE with all outputs at their reset values.

Structure
REQ-032 SHALL place FSM state encoding and default parameter constants in shared package twi_pkg.
REQ-033 SHALL instantiate sub-module twi_glitch_filter (synchroniser + filter, one line) twice.

Verification
REQ-034 SDA glitch of 3 clocks with FILTER_CYCLES=4 -> core_sda_o stays 1, no start_o.
REQ-035 SDA low with SCL high for 10 clocks -> start_o pulses at clock 6 after the edge, busy_o=1; SDA high -> stop_o, busy_o=0.
REQ-036 TIMEOUT_CYCLES=100, SCL held low in ACTIVE -> timeout_o at count 100, core sees SDA low 16 clk then high 16 clk with SCL=1, pad_*_o=1 throughout.
REQ-037 clr_timeout_i and timeout set in the same cycle -> timeout_o=1; clr alone the next cycle -> timeout_o=0.
REQ-038 rstn_i low during REC_LOW -> all outputs at reset values the same cycle, FSM IDLE after release.
